// File: rtl/text_pkg.sv
// Shared types and attribute field layout for the text-mode glyph pixel stage.
package text_pkg;
  localparam int COLOR_BITS     = 4;
  localparam int ATTR_FG_LSB    = 0;
  localparam int ATTR_BG_LSB    = 4;
  localparam int ATTR_BLINK_BIT = 7;
  localparam int FONT_ROWS      = 16;
  localparam int GLYPH_W        = 8;

  typedef logic [COLOR_BITS-1:0] color_t;
endpackage

// File: rtl/text_shift8.sv
// Glyph byte serialiser: loads a byte plus fg/bg, emits one colour per clk MSB-first.
module text_shift8
  import text_pkg::*;
#(
  parameter int COLOR_W = COLOR_BITS
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic [GLYPH_W-1:0] data_i,
  input  logic [COLOR_W-1:0] fg_i,
  input  logic [COLOR_W-1:0] bg_i,
  output logic               busy_o,
  output logic               last_o,
  output logic               pix_valid_o,
  output logic [COLOR_W-1:0] pix_color_o
);
  logic [GLYPH_W-1:0] sr;
  logic [COLOR_W-1:0] fg, bg;
  logic [2:0]         cnt;
  logic               busy;

  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      sr   <= '0;
      fg   <= '0;
      bg   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load_i) begin
      sr   <= data_i;
      fg   <= fg_i;
      bg   <= bg_i;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      sr  <= sr << 1;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) busy <= 1'b0;
    end
  end

  assign busy_o      = busy;
  assign last_o      = busy && (cnt == 3'd7);
  assign pix_valid_o = busy;
  assign pix_color_o = busy ? (sr[GLYPH_W-1] ? fg : bg) : '0;
endmodule

// File: rtl/text_glyph_shifter.sv
// Text-mode pixel stage: cell handshake -> font BRAM read -> hold -> 8-pixel serialiser.
// Optional blink attribute enabled by defining TEXT_BLINK_EN.
module text_glyph_shifter
  import text_pkg::*;
#(
  parameter int FONT_ADDR_W = 13,
  parameter int COLOR_W     = COLOR_BITS
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   font_bank_i,
`ifdef TEXT_BLINK_EN
  input  logic                   blink_phase_i,
`endif
  input  logic                   cell_valid_i,
  output logic                   cell_ready_o,
  input  logic [7:0]             cell_char_i,
  input  logic [7:0]             cell_attr_i,
  input  logic [3:0]             cell_row_i,
  output logic                   font_rd_en_o,
  output logic [FONT_ADDR_W-1:0] font_rd_addr_o,
  input  logic [GLYPH_W-1:0]     font_rd_data_i,
  output logic                   pix_valid_o,
  output logic [COLOR_W-1:0]     pix_color_o
);
  logic               pend, hold_valid, accept, load;
  logic [7:0]         pend_attr, hold_attr;
  logic [GLYPH_W-1:0] hold_data, load_data;
  logic [COLOR_W-1:0] fg, bg, sh_color;
  logic               sh_busy, sh_last, sh_valid;

  // One cell in flight at a time; the hold slot lets the next read overlap shifting.
  assign cell_ready_o   = !pend && !hold_valid && !reset_i && !flush_i;
  assign accept         = cell_valid_i && cell_ready_o;
  assign font_rd_en_o   = accept;
  assign font_rd_addr_o = accept ? FONT_ADDR_W'({font_bank_i, cell_char_i, cell_row_i}) : '0;

  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      pend       <= 1'b0;
      pend_attr  <= '0;
      hold_valid <= 1'b0;
      hold_attr  <= '0;
      hold_data  <= '0;
    end else begin
      pend <= accept;
      if (accept) pend_attr <= cell_attr_i;
      if (pend) begin
        hold_valid <= 1'b1;
        hold_data  <= font_rd_data_i;
        hold_attr  <= pend_attr;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign load = hold_valid && (!sh_busy || sh_last) && !flush_i && !reset_i;
  assign fg   = hold_attr[ATTR_FG_LSB +: COLOR_W];

`ifdef TEXT_BLINK_EN
  // Blinked-off cells are loaded as all-background.
  assign bg        = {1'b0, hold_attr[ATTR_BG_LSB +: COLOR_W-1]};
  assign load_data = (hold_attr[ATTR_BLINK_BIT] && blink_phase_i) ? '0 : hold_data;
`else
  assign bg        = hold_attr[ATTR_BG_LSB +: COLOR_W];
  assign load_data = hold_data;
`endif

  text_shift8 #(.COLOR_W(COLOR_W)) u_shift (
    .clk         (clk),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .load_i      (load),
    .data_i      (load_data),
    .fg_i        (fg),
    .bg_i        (bg),
    .busy_o      (sh_busy),
    .last_o      (sh_last),
    .pix_valid_o (sh_valid),
    .pix_color_o (sh_color)
  );

  assign pix_valid_o = sh_valid && !reset_i;
  assign pix_color_o = reset_i ? '0 : sh_color;
endmodule

// File: tb/tb_text_glyph_shifter.sv
// Directed self-checking bench for text_glyph_shifter with a registered font BRAM model.
module tb_text_glyph_shifter;
  logic        clk = 1'b0;
  logic        reset_i, flush_i, font_bank_i, cell_valid_i;
  logic [7:0]  cell_char_i, cell_attr_i;
  logic [3:0]  cell_row_i;
  logic        cell_ready_o, font_rd_en_o;
  logic [12:0] font_rd_addr_o;
  logic [7:0]  font_rd_data_i = 8'h00;
  logic        pix_valid_o;
  logic [3:0]  pix_color_o;
`ifdef TEXT_BLINK_EN
  logic        blink_phase_i = 1'b0;
`endif

  int pass_cnt = 0;
  int total    = 0;
  logic [7:0] font_mem [0:8191];

  text_glyph_shifter dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .font_bank_i    (font_bank_i),
`ifdef TEXT_BLINK_EN
    .blink_phase_i  (blink_phase_i),
`endif
    .cell_valid_i   (cell_valid_i),
    .cell_ready_o   (cell_ready_o),
    .cell_char_i    (cell_char_i),
    .cell_attr_i    (cell_attr_i),
    .cell_row_i     (cell_row_i),
    .font_rd_en_o   (font_rd_en_o),
    .font_rd_addr_o (font_rd_addr_o),
    .font_rd_data_i (font_rd_data_i),
    .pix_valid_o    (pix_valid_o),
    .pix_color_o    (pix_color_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (font_rd_en_o) font_rd_data_i <= font_mem[font_rd_addr_o];

  // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
  task tick();
    @(posedge clk);
    #1;
  endtask

  task settle();
    #3;
  endtask

  task present(input logic [7:0] ch, input logic [3:0] row, input logic [7:0] attr, input logic bank);
    cell_valid_i = 1'b1;
    cell_char_i  = ch;
    cell_row_i   = row;
    cell_attr_i  = attr;
    font_bank_i  = bank;
  endtask

  task test_reset();
    reset_i = 1'b1;
    flush_i = 1'b0;
    present(8'hFF, 4'hF, 8'h77, 1'b1);
    tick(); tick(); settle();
    total++; if (cell_ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", cell_ready_o); else pass_cnt++;
    total++; if (font_rd_en_o !== 1'b0 || font_rd_addr_o !== 13'h0)
      $display("FAIL reset_rd got en=%b addr=%h want en=0 addr=0000", font_rd_en_o, font_rd_addr_o); else pass_cnt++;
    total++; if (pix_valid_o !== 1'b0 || pix_color_o !== 4'h0)
      $display("FAIL reset_pix got v=%b c=%h want v=0 c=0", pix_valid_o, pix_color_o); else pass_cnt++;
    tick();
    reset_i = 1'b0;
    cell_valid_i = 1'b0;
    settle();
    total++; if (cell_ready_o !== 1'b1) $display("FAIL reset_release_ready got %b want 1", cell_ready_o); else pass_cnt++;
    total++; if (pix_valid_o !== 1'b0) $display("FAIL reset_release_pix got %b want 0", pix_valid_o); else pass_cnt++;
  endtask

  task test_single();
    logic [3:0] exp [8];
    exp = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'hF, 4'h1, 4'hF};
    tick();
    present(8'h41, 4'd3, 8'h1F, 1'b0);
    settle();
    total++; if (cell_ready_o !== 1'b1 || font_rd_en_o !== 1'b1)
      $display("FAIL single_accept got rdy=%b en=%b want 1 1", cell_ready_o, font_rd_en_o); else pass_cnt++;
    total++; if (font_rd_addr_o !== 13'h0413) $display("FAIL single_addr got %h want 0413", font_rd_addr_o); else pass_cnt++;
    for (int t = 1; t <= 12; t++) begin
      tick();
      cell_valid_i = 1'b0;
      settle();
      if (t == 1) begin
        total++; if (font_rd_en_o !== 1'b0 || font_rd_addr_o !== 13'h0)
          $display("FAIL single_rd_idle got en=%b addr=%h want 0 0000", font_rd_en_o, font_rd_addr_o); else pass_cnt++;
      end
      if (t >= 3 && t <= 10) begin
        total++; if (pix_valid_o !== 1'b1 || pix_color_o !== exp[t-3])
          $display("FAIL single_pix t=%0d got v=%b c=%h want v=1 c=%h", t, pix_valid_o, pix_color_o, exp[t-3]); else pass_cnt++;
      end else begin
        total++; if (pix_valid_o !== 1'b0 || pix_color_o !== 4'h0)
          $display("FAIL single_gap t=%0d got v=%b c=%h want v=0 c=0", t, pix_valid_o, pix_color_o); else pass_cnt++;
      end
    end
  endtask

  task test_continuous();
    logic [7:0]  cg [4];
    logic [7:0]  ca [4];
    logic [7:0]  cc [4];
    logic        cb [4];
    logic [12:0] caddr [4];
    int          acc_t [4];
    int          idx;
    logic [3:0]  e;
    logic [7:0]  g;
    cg = '{8'hF0, 8'h81, 8'h3C, 8'h0F};
    ca = '{8'h2C, 8'h3D, 8'h45, 8'h67};
    cc = '{8'h10, 8'h11, 8'h12, 8'h13};
    cb = '{1'b0, 1'b0, 1'b0, 1'b1};
    caddr = '{13'h0100, 13'h0110, 13'h0120, 13'h1130};
    acc_t = '{0, 3, 11, 19};
    idx = 0;
    for (int t = 0; t <= 36; t++) begin
      tick();
      if (idx < 4) present(cc[idx], 4'd0, ca[idx], cb[idx]);
      else cell_valid_i = 1'b0;
      settle();
      if (cell_valid_i && cell_ready_o) begin
        total++; if (t != acc_t[idx] || font_rd_addr_o !== caddr[idx])
          $display("FAIL cont_accept%0d got t=%0d addr=%h want t=%0d addr=%h", idx, t, font_rd_addr_o, acc_t[idx], caddr[idx]);
        else pass_cnt++;
        idx++;
      end
      if (t >= 3 && t <= 34) begin
        g = cg[(t-3)/8];
        e = g[7-((t-3)%8)] ? ca[(t-3)/8][3:0] : ca[(t-3)/8][7:4];
        total++; if (pix_valid_o !== 1'b1 || pix_color_o !== e)
          $display("FAIL cont_pix t=%0d got v=%b c=%h want v=1 c=%h", t, pix_valid_o, pix_color_o, e); else pass_cnt++;
      end else begin
        total++; if (pix_valid_o !== 1'b0)
          $display("FAIL cont_gap t=%0d got v=%b want v=0", t, pix_valid_o); else pass_cnt++;
      end
    end
    total++; if (idx != 4) $display("FAIL cont_count got %0d accepts want 4", idx); else pass_cnt++;
  endtask

  task test_valid_gap();
    logic [7:0] ga, gb;
    logic [3:0] e;
    ga = 8'hC3;
    gb = 8'h99;
    for (int t = 0; t <= 25; t++) begin
      tick();
      if (t == 0) present(8'h20, 4'd0, 8'h5A, 1'b0);
      else if (t == 13) present(8'h21, 4'd0, 8'h6B, 1'b0);
      else cell_valid_i = 1'b0;
      settle();
      if (t == 0 || t == 13) begin
        total++; if (cell_ready_o !== 1'b1) $display("FAIL gap_ready t=%0d got %b want 1", t, cell_ready_o); else pass_cnt++;
      end
      if (t >= 3 && t <= 10) begin
        e = ga[10-t] ? 4'hA : 4'h5;
        total++; if (pix_valid_o !== 1'b1 || pix_color_o !== e)
          $display("FAIL gap_pix_a t=%0d got v=%b c=%h want v=1 c=%h", t, pix_valid_o, pix_color_o, e); else pass_cnt++;
      end else if (t >= 16 && t <= 23) begin
        e = gb[23-t] ? 4'hB : 4'h6;
        total++; if (pix_valid_o !== 1'b1 || pix_color_o !== e)
          $display("FAIL gap_pix_b t=%0d got v=%b c=%h want v=1 c=%h", t, pix_valid_o, pix_color_o, e); else pass_cnt++;
      end else begin
        total++; if (pix_valid_o !== 1'b0 || pix_color_o !== 4'h0)
          $display("FAIL gap_idle t=%0d got v=%b c=%h want v=0 c=0", t, pix_valid_o, pix_color_o); else pass_cnt++;
      end
    end
  endtask

  task test_flush();
    for (int t = 0; t <= 12; t++) begin
      tick();
      flush_i = (t == 1);
      if (t <= 1) present(8'h30, 4'd5, 8'h12, 1'b0);
      else cell_valid_i = 1'b0;
      settle();
      if (t == 0) begin
        total++; if (cell_ready_o !== 1'b1 || font_rd_addr_o !== 13'h0305)
          $display("FAIL flush_accept got rdy=%b addr=%h want 1 0305", cell_ready_o, font_rd_addr_o); else pass_cnt++;
      end
      if (t == 1) begin
        total++; if (cell_ready_o !== 1'b0 || font_rd_en_o !== 1'b0)
          $display("FAIL flush_no_accept got rdy=%b en=%b want 0 0", cell_ready_o, font_rd_en_o); else pass_cnt++;
      end
      if (t == 2) begin
        total++; if (cell_ready_o !== 1'b1) $display("FAIL flush_ready got %b want 1", cell_ready_o); else pass_cnt++;
      end
      total++; if (pix_valid_o !== 1'b0 || pix_color_o !== 4'h0)
        $display("FAIL flush_pix t=%0d got v=%b c=%h want v=0 c=0", t, pix_valid_o, pix_color_o); else pass_cnt++;
    end
    flush_i = 1'b0;
  endtask

  task test_reset_mid();
    logic [3:0] exp [3];
    exp = '{4'h4, 4'h3, 4'h4};
    for (int t = 0; t <= 16; t++) begin
      tick();
      reset_i = (t == 6);
      if (t == 0 || t == 6) present(8'h40, 4'd7, 8'h34, 1'b0);
      else cell_valid_i = 1'b0;
      settle();
      if (t == 0) begin
        total++; if (font_rd_addr_o !== 13'h0407) $display("FAIL rmid_addr got %h want 0407", font_rd_addr_o); else pass_cnt++;
      end
      if (t >= 3 && t <= 5) begin
        total++; if (pix_valid_o !== 1'b1 || pix_color_o !== exp[t-3])
          $display("FAIL rmid_pix t=%0d got v=%b c=%h want v=1 c=%h", t, pix_valid_o, pix_color_o, exp[t-3]); else pass_cnt++;
      end
      if (t == 6) begin
        total++; if (cell_ready_o !== 1'b0 || font_rd_en_o !== 1'b0 || font_rd_addr_o !== 13'h0)
          $display("FAIL rmid_ctrl got rdy=%b en=%b addr=%h want 0 0 0000", cell_ready_o, font_rd_en_o, font_rd_addr_o); else pass_cnt++;
      end
      if (t == 7) begin
        total++; if (cell_ready_o !== 1'b1) $display("FAIL rmid_ready got %b want 1", cell_ready_o); else pass_cnt++;
      end
      if (t >= 6) begin
        total++; if (pix_valid_o !== 1'b0 || pix_color_o !== 4'h0)
          $display("FAIL rmid_trunc t=%0d got v=%b c=%h want v=0 c=0", t, pix_valid_o, pix_color_o); else pass_cnt++;
      end
    end
    reset_i = 1'b0;
  endtask

`ifdef TEXT_BLINK_EN
  task test_blink();
    logic [3:0] e;
    for (int p = 1; p >= 0; p--) begin
      e = (p == 1) ? 4'h1 : 4'hE;
      for (int t = 0; t <= 11; t++) begin
        tick();
        blink_phase_i = p[0];
        if (t == 0) present(8'h50, 4'd0, 8'h9E, 1'b0);
        else cell_valid_i = 1'b0;
        settle();
        if (t >= 3 && t <= 10) begin
          total++; if (pix_valid_o !== 1'b1 || pix_color_o !== e)
            $display("FAIL blink%0d_pix t=%0d got v=%b c=%h want v=1 c=%h", p, t, pix_valid_o, pix_color_o, e); else pass_cnt++;
        end else begin
          total++; if (pix_valid_o !== 1'b0)
            $display("FAIL blink%0d_gap t=%0d got v=%b want v=0", p, t, pix_valid_o); else pass_cnt++;
        end
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8192; i++) font_mem[i] = 8'h00;
    font_mem[13'h0413] = 8'hA5;
    font_mem[13'h0100] = 8'hF0;
    font_mem[13'h0110] = 8'h81;
    font_mem[13'h0120] = 8'h3C;
    font_mem[13'h1130] = 8'h0F;
    font_mem[13'h0200] = 8'hC3;
    font_mem[13'h0210] = 8'h99;
    font_mem[13'h0305] = 8'hFF;
    font_mem[13'h0407] = 8'hB6;
    font_mem[13'h0500] = 8'hFF;
    reset_i = 1'b1; flush_i = 1'b0; cell_valid_i = 1'b0;
    cell_char_i = 8'h00; cell_attr_i = 8'h00; cell_row_i = 4'h0; font_bank_i = 1'b0;
    test_reset();
    test_single();
    test_continuous();
    test_valid_gap();
    test_flush();
    test_reset_mid();
`ifdef TEXT_BLINK_EN
    test_blink();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
